// File: rtl/seq_loop_monitor.sv
// Passive monitor for an HLS-style block handshake and one loop inside the observed FSM.
// Collects saturating transaction and loop statistics and freezes them once finish is seen.
module seq_loop_monitor #(
   parameter int STATE_W = 3,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ap_start,
   input  logic               ap_ready,
   input  logic               ap_done,
   input  logic               ap_continue,
   input  logic               finish,
   input  logic [STATE_W-1:0] cur_state,
   input  logic [STATE_W-1:0] pre_loop_state0,
   input  logic [STATE_W-1:0] post_loop_state0,
   input  logic [STATE_W-1:0] quit_loop_state0,
   input  logic [STATE_W-1:0] iter_start_state,
   input  logic [STATE_W-1:0] iter_end_state0,
   input  logic               pre_states_valid,
   input  logic               post_states_valid,
   input  logic               quit_states_valid,
   input  logic               iter_end_states_valid,
   input  logic               one_state_loop,
   input  logic               one_state_block,
   output logic               mod_busy,
   output logic [CNT_W-1:0]   mod_start_cnt,
   output logic [CNT_W-1:0]   mod_done_cnt,
   output logic [CNT_W-1:0]   mod_last_lat,
   output logic               loop_active,
   output logic [CNT_W-1:0]   loop_exec_cnt,
   output logic [CNT_W-1:0]   loop_iter_cnt,
   output logic [CNT_W-1:0]   loop_last_trip,
   output logic [CNT_W-1:0]   loop_last_iter_cyc,
   output logic               frozen
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_WAIT = 2'd2
   } mod_state_t;

   mod_state_t         state;
   mod_state_t         state_nxt;
   logic [CNT_W-1:0]   lat_cnt;
   logic [CNT_W-1:0]   iter_cyc;
   logic [STATE_W-1:0] prev_state;
   logic               upd;
   logic               start_hit;
   logic               iter_end;
   logic               loop_exit;
   logic               entry_ok;
   logic [CNT_W-1:0]   iters_now;
   logic               ready_unused;

   // The edge that samples finish already counts as frozen, so nothing moves on it.
   assign upd          = !frozen && !finish;
   assign ready_unused = ap_ready;
   assign mod_busy     = (state == S_BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (ap_start) begin
               if (ap_done) state_nxt = ap_continue ? S_IDLE : S_WAIT;
               else         state_nxt = S_BUSY;
            end
         end
         S_BUSY: if (ap_done) state_nxt = ap_continue ? S_IDLE : S_WAIT;
         S_WAIT: if (ap_continue) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (!upd) state_nxt = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mod_start_cnt <= CNT_ZERO;
         mod_done_cnt  <= CNT_ZERO;
         mod_last_lat  <= CNT_ZERO;
         lat_cnt       <= CNT_ZERO;
         frozen        <= 1'b0;
      end else begin
         if (finish) frozen <= 1'b1;
         if (upd) begin
            case (state)
               S_IDLE: begin
                  if (ap_start) begin
                     mod_start_cnt <= sat_inc(mod_start_cnt);
                     lat_cnt       <= CNT_ONE;
                     if (ap_done) begin
                        mod_done_cnt <= sat_inc(mod_done_cnt);
                        mod_last_lat <= CNT_ONE;
                     end
                  end
               end
               S_BUSY: begin
                  lat_cnt <= sat_inc(lat_cnt);
                  if (ap_done) begin
                     mod_done_cnt <= sat_inc(mod_done_cnt);
                     mod_last_lat <= sat_inc(lat_cnt);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign start_hit = (cur_state == iter_start_state);
   assign iter_end  = loop_active &&
                      ((iter_end_states_valid && (cur_state == iter_end_state0)) ||
                       (one_state_loop && start_hit));
   assign loop_exit = loop_active && quit_states_valid && (prev_state == quit_loop_state0) &&
                      post_states_valid && (cur_state == post_loop_state0);
   assign entry_ok  = start_hit &&
                      (!one_state_block || !pre_states_valid || (prev_state == pre_loop_state0));
   assign iters_now = iter_end ? sat_inc(loop_iter_cnt) : loop_iter_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_state         <= '0;
         loop_active        <= 1'b0;
         loop_exec_cnt      <= CNT_ZERO;
         loop_iter_cnt      <= CNT_ZERO;
         loop_last_trip     <= CNT_ZERO;
         loop_last_iter_cyc <= CNT_ZERO;
         iter_cyc           <= CNT_ZERO;
      end else if (upd) begin
         prev_state <= cur_state;
         if (loop_active) begin
            // iter_cyc restarts at 0 so the next body cycle counts as 1.
            if (iter_end) begin
               loop_last_iter_cyc <= sat_inc(iter_cyc);
               iter_cyc           <= CNT_ZERO;
            end else begin
               iter_cyc <= sat_inc(iter_cyc);
            end
            loop_iter_cnt <= iters_now;
            if (loop_exit) begin
               loop_last_trip <= iters_now;
               loop_active    <= 1'b0;
               if (entry_ok) begin
                  loop_active   <= 1'b1;
                  loop_exec_cnt <= sat_inc(loop_exec_cnt);
                  loop_iter_cnt <= CNT_ZERO;
                  iter_cyc      <= CNT_ONE;
               end
            end
         end else if (entry_ok) begin
            loop_active   <= 1'b1;
            loop_exec_cnt <= sat_inc(loop_exec_cnt);
            loop_iter_cnt <= CNT_ZERO;
            iter_cyc      <= CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_seq_loop_monitor.sv
// Bench for seq_loop_monitor: handshake vector table, loop corner sequences and a
// randomized run against a timestamp-based reference model (counters narrowed to 4 bits).
module tb_seq_loop_monitor;

   localparam int SW   = 3;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 0, finish = 0;
   logic [SW-1:0] cur_state = '0;
   logic [SW-1:0] pre_c = '0, post_c = '0, quit_c = '0, start_c = '0, end_c = '0;
   logic          pre_v = 0, post_v = 0, quit_v = 0, end_v = 0, osl = 0, osb = 0;
   logic          mod_busy, loop_active, frozen;
   logic [CW-1:0] mod_start_cnt, mod_done_cnt, mod_last_lat;
   logic [CW-1:0] loop_exec_cnt, loop_iter_cnt, loop_last_trip, loop_last_iter_cyc;

   seq_loop_monitor #(.STATE_W(SW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .finish(finish), .cur_state(cur_state),
      .pre_loop_state0(pre_c), .post_loop_state0(post_c), .quit_loop_state0(quit_c),
      .iter_start_state(start_c), .iter_end_state0(end_c),
      .pre_states_valid(pre_v), .post_states_valid(post_v), .quit_states_valid(quit_v),
      .iter_end_states_valid(end_v), .one_state_loop(osl), .one_state_block(osb),
      .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
      .mod_last_lat(mod_last_lat), .loop_active(loop_active), .loop_exec_cnt(loop_exec_cnt),
      .loop_iter_cnt(loop_iter_cnt), .loop_last_trip(loop_last_trip),
      .loop_last_iter_cyc(loop_last_iter_cyc), .frozen(frozen)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: transaction and iteration lengths come from cycle timestamps.
   int cyc = 0;
   bit m_txn, m_wait, m_loop, m_frozen;
   int m_starts, m_dones, m_last_lat, m_t0;
   int m_execs, m_iters, m_trip, m_last_iter, m_it0, m_prev;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic model_reset();
      m_txn = 0; m_wait = 0; m_loop = 0; m_frozen = 0;
      m_starts = 0; m_dones = 0; m_last_lat = 0; m_t0 = 0;
      m_execs = 0; m_iters = 0; m_trip = 0; m_last_iter = 0; m_it0 = 0; m_prev = 0;
   endtask

   task automatic model_update();
      bit is_end, is_exit, can_enter;
      if (!m_frozen && !finish) begin
         if (m_txn) begin
            if (ap_done) begin
               m_dones++; m_last_lat = cyc - m_t0 + 1; m_txn = 0; m_wait = !ap_continue;
            end
         end else if (m_wait) begin
            if (ap_continue) m_wait = 0;
         end else if (ap_start) begin
            m_starts++; m_t0 = cyc;
            if (ap_done) begin
               m_dones++; m_last_lat = 1; m_wait = !ap_continue;
            end else m_txn = 1;
         end
         is_end    = (end_v && int'(cur_state) == int'(end_c)) || (osl && cur_state == start_c);
         is_exit   = quit_v && m_prev == int'(quit_c) && post_v && cur_state == post_c;
         can_enter = (cur_state == start_c) && (!osb || !pre_v || m_prev == int'(pre_c));
         if (m_loop) begin
            if (is_end) begin
               m_iters++; m_last_iter = cyc - m_it0 + 1; m_it0 = cyc + 1;
            end
            if (is_exit) begin
               m_trip = m_iters; m_loop = 0;
            end
         end
         if (!m_loop && can_enter) begin
            m_loop = 1; m_execs++; m_iters = 0; m_it0 = cyc;
         end
         m_prev = int'(cur_state);
      end
      if (finish) m_frozen = 1;
      cyc++;
   endtask

   task automatic compare_all();
      check("mod_busy", int'(mod_busy), int'(m_txn));
      check("mod_start_cnt", int'(mod_start_cnt), sat(m_starts));
      check("mod_done_cnt", int'(mod_done_cnt), sat(m_dones));
      check("mod_last_lat", int'(mod_last_lat), sat(m_last_lat));
      check("loop_active", int'(loop_active), int'(m_loop));
      check("loop_exec_cnt", int'(loop_exec_cnt), sat(m_execs));
      check("loop_iter_cnt", int'(loop_iter_cnt), sat(m_iters));
      check("loop_last_trip", int'(loop_last_trip), sat(m_trip));
      check("loop_last_iter_cyc", int'(loop_last_iter_cyc), sat(m_last_iter));
      check("frozen", int'(frozen), int'(m_frozen));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic go(input logic [SW-1:0] s);
      cur_state = s;
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"}, int'(mod_busy), 0);
      check({tag, ".start"}, int'(mod_start_cnt), 0);
      check({tag, ".done"}, int'(mod_done_cnt), 0);
      check({tag, ".lat"}, int'(mod_last_lat), 0);
      check({tag, ".active"}, int'(loop_active), 0);
      check({tag, ".exec"}, int'(loop_exec_cnt), 0);
      check({tag, ".iter"}, int'(loop_iter_cnt), 0);
      check({tag, ".trip"}, int'(loop_last_trip), 0);
      check({tag, ".itercyc"}, int'(loop_last_iter_cyc), 0);
      check({tag, ".frozen"}, int'(frozen), 0);
   endtask

   // Reset is asserted away from any clock edge and checked before the next one.
   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero(tag);
      ap_start = 0; ap_done = 0; ap_continue = 0; finish = 0; cur_state = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_codes(input int pre, input int st, input int en, input int qu, input int po);
      pre_c = SW'(pre); start_c = SW'(st); end_c = SW'(en); quit_c = SW'(qu); post_c = SW'(po);
      pre_v = 1; post_v = 1; quit_v = 1; end_v = 1; osl = 0; osb = 0;
   endtask

   typedef struct {
      bit rst_first;
      bit st, dn, ct, rdy;
      bit busy;
      int sc, dc, lat;
   } hs_vec_t;

   hs_vec_t tbl[15];

   initial begin
      tbl[0]  = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
      tbl[4]  = '{0, 0, 1, 1, 0, 0, 1, 1, 5};
      tbl[5]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
      tbl[6]  = '{0, 1, 1, 1, 1, 0, 2, 2, 1};
      tbl[7]  = '{0, 1, 1, 1, 0, 0, 3, 3, 1};
      tbl[8]  = '{0, 1, 0, 0, 0, 1, 4, 3, 1};
      tbl[9]  = '{0, 0, 1, 0, 1, 0, 4, 4, 2};
      tbl[10] = '{0, 1, 0, 0, 0, 0, 4, 4, 2};
      tbl[11] = '{0, 0, 0, 1, 0, 0, 4, 4, 2};
      tbl[12] = '{0, 1, 1, 0, 0, 0, 5, 5, 1};
      tbl[13] = '{0, 1, 0, 1, 1, 0, 5, 5, 1};
      tbl[14] = '{0, 1, 0, 0, 0, 1, 6, 5, 1};

      model_reset();
      set_codes(1, 2, 3, 2, 1);
      #3;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Handshake vectors; cur_state stays 0 so the loop side stays idle.
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rst_first) do_reset($sformatf("hs_rst%0d", i));
         ap_start = tbl[i].st; ap_done = tbl[i].dn; ap_continue = tbl[i].ct; ap_ready = tbl[i].rdy;
         step();
         check($sformatf("hs[%0d].busy", i), int'(mod_busy), int'(tbl[i].busy));
         check($sformatf("hs[%0d].start", i), int'(mod_start_cnt), tbl[i].sc);
         check($sformatf("hs[%0d].done", i), int'(mod_done_cnt), tbl[i].dc);
         check($sformatf("hs[%0d].lat", i), int'(mod_last_lat), tbl[i].lat);
      end
      ap_start = 0; ap_done = 0; ap_continue = 0; ap_ready = 0;

      // Two-iteration loop.
      do_reset("rst_loopA");
      set_codes(1, 2, 3, 2, 1);
      go(1); go(2); go(3); go(2); go(3);
      check("loopA.iter_mid", int'(loop_iter_cnt), 2);
      check("loopA.active_mid", int'(loop_active), 1);
      go(2); go(1);
      check("loopA.exec", int'(loop_exec_cnt), 1);
      check("loopA.trip", int'(loop_last_trip), 2);
      check("loopA.itercyc", int'(loop_last_iter_cyc), 2);
      check("loopA.active", int'(loop_active), 0);

      // Entered and left with no iteration.
      do_reset("rst_loopB");
      go(1); go(2); go(1);
      check("loopB.exec", int'(loop_exec_cnt), 1);
      check("loopB.trip", int'(loop_last_trip), 0);
      check("loopB.active", int'(loop_active), 0);

      // Exit and re-entry on the same cycle (post state == start state).
      do_reset("rst_loopC");
      set_codes(1, 2, 3, 3, 2);
      go(0); go(2); go(3); go(2);
      check("loopC.exec", int'(loop_exec_cnt), 2);
      check("loopC.trip", int'(loop_last_trip), 1);
      check("loopC.active", int'(loop_active), 1);
      check("loopC.iter", int'(loop_iter_cnt), 0);

      // Entry block guard.
      do_reset("rst_loopD");
      set_codes(1, 2, 3, 2, 1);
      osb = 1;
      go(0); go(2);
      check("loopD.no_entry", int'(loop_active), 0);
      go(1); go(2);
      check("loopD.entry", int'(loop_active), 1);
      check("loopD.exec", int'(loop_exec_cnt), 1);

      // Randomized run.
      for (int seg = 0; seg < 8; seg++) begin
         if (seg == 4) do_reset("rst_rand");
         pre_c = SW'($urandom_range(0, 7)); start_c = SW'($urandom_range(0, 7));
         end_c = SW'($urandom_range(0, 7)); quit_c = SW'($urandom_range(0, 7));
         post_c = SW'($urandom_range(0, 7));
         pre_v = ($urandom_range(0, 5) != 0); post_v = ($urandom_range(0, 5) != 0);
         quit_v = ($urandom_range(0, 5) != 0); end_v = ($urandom_range(0, 5) != 0);
         osl = ($urandom_range(0, 2) == 0); osb = ($urandom_range(0, 1) == 0);
         for (int i = 0; i < 200; i++) begin
            ap_start = ($urandom_range(0, 2) == 0);
            ap_done = ($urandom_range(0, 3) == 0);
            ap_continue = ($urandom_range(0, 1) == 0);
            ap_ready = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 7))
               0: cur_state = start_c;
               1: cur_state = end_c;
               2: cur_state = quit_c;
               3: cur_state = post_c;
               4: cur_state = pre_c;
               default: cur_state = SW'($urandom_range(0, 7));
            endcase
            step();
         end
      end

      // Freeze mid-loop, then keep driving activity.
      do_reset("rst_freeze");
      set_codes(1, 2, 3, 2, 1);
      ap_start = 0; ap_done = 0; ap_continue = 1;
      go(1); go(2); go(3);
      finish = 1; ap_start = 1;
      go(2);
      finish = 0;
      go(3); go(2); go(1);
      check("freeze.frozen", int'(frozen), 1);
      check("freeze.active", int'(loop_active), 1);
      check("freeze.exec", int'(loop_exec_cnt), 1);
      check("freeze.iter", int'(loop_iter_cnt), 1);
      check("freeze.trip", int'(loop_last_trip), 0);
      check("freeze.itercyc", int'(loop_last_iter_cyc), 2);
      check("freeze.start", int'(mod_start_cnt), 0);
      check("freeze.busy", int'(mod_busy), 0);

      // Reset mid-transaction clears everything without a clock edge.
      do_reset("rst_mid0");
      ap_start = 1;
      step();
      ap_start = 0;
      step();
      check("mid.busy_before", int'(mod_busy), 1);
      do_reset("rst_mid");
      step();
      check("mid.done_after", int'(mod_done_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_loop_monitor.md
SEQ_LOOP_MONITOR -- requirements
Module: seq_loop_monitor

Interface
REQ-001 Parameter STATE_W, default 3, width of the observed FSM state encoding.
REQ-002 Parameter CNT_W, default 32, width of every counter output.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 ap_start, ap_ready, ap_done, ap_continue  input  1 each  observed module block-level handshake.
REQ-006 finish  input  1  end-of-run request; freezes all statistics.
REQ-007 cur_state  input  STATE_W  observed FSM current state.
REQ-008 pre_loop_state0, post_loop_state0, quit_loop_state0, iter_start_state, iter_end_state0  input  STATE_W each  loop state codes.
REQ-009 pre_states_valid, post_states_valid, quit_states_valid, iter_end_states_valid  input  1 each  qualify the matching state code; an invalid code never matches.
REQ-010 one_state_loop, one_state_block  input  1 each  loop-body / entry-block shape flags.
REQ-011 mod_busy  output  1  module transaction in progress.
REQ-012 mod_start_cnt, mod_done_cnt, mod_last_lat  output  CNT_W each  starts, completions, latency of the last transaction.
REQ-013 loop_active  output  1  inside the monitored loop.
REQ-014 loop_exec_cnt, loop_iter_cnt, loop_last_trip, loop_last_iter_cyc  output  CNT_W each  loop entries, iterations of the current execution, trip count of the last completed execution, cycles of the last iteration.
REQ-015 frozen  output  1  statistics frozen by finish.

Function
REQ-016 Module FSM states IDLE, BUSY, WAIT_CONT.
REQ-017 IDLE with ap_start=1: mod_start_cnt +1; latency counter loads 1; next state BUSY.
REQ-018 BUSY: latency counter +1 each cycle; on ap_done=1, mod_done_cnt +1 and mod_last_lat takes the latency count including the done cycle.
REQ-019 BUSY with ap_done=1: next state IDLE if ap_continue=1, else WAIT_CONT.
REQ-020 WAIT_CONT: next state IDLE on ap_continue=1.
REQ-021 IDLE with ap_start=1 and ap_done=1 in the same cycle: start and done both counted, mod_last_lat=1, FSM stays IDLE (or WAIT_CONT when ap_continue=0).
REQ-022 mod_busy=1 in BUSY only.
REQ-023 ap_ready is informational only and never changes module FSM state.
REQ-024 prev_state register holds cur_state from the previous cycle.
REQ-025 Loop entry: loop_active=0 and cur_state==iter_start_state -> loop_active=1, loop_exec_cnt +1, loop_iter_cnt=0, iteration cycle counter loads 1.
REQ-026 Iteration end: loop_active=1, iter_end_states_valid=1 and cur_state==iter_end_state0 -> loop_iter_cnt +1; loop_last_iter_cyc takes the iteration cycle count; iteration cycle counter restarts.
REQ-027 one_state_loop=1: every loop_active cycle with cur_state==iter_start_state is an iteration end.
REQ-028 Loop exit: loop_active=1 and prev_state==quit_loop_state0 (valid) and cur_state==post_loop_state0 (valid) -> loop_active=0, loop_last_trip takes the iteration count including any iteration ending that cycle.
REQ-029 Exit and re-entry in the same cycle (post state equals iter_start_state): the exit is processed, then a new entry.
REQ-030 one_state_block=1: entry additionally requires prev_state==pre_loop_state0 when pre_states_valid=1.
REQ-031 All counters saturate at all-ones; no wrap-around.
REQ-032 finish=1 sampled on a rising edge sets frozen=1; frozen is sticky until reset; while frozen=1 no output changes.

Reset
REQ-033 reset=0 asynchronously clears all counters, mod_busy, loop_active and frozen; module FSM goes to IDLE; prev_state clears to 0.
REQ-034 Reset asserted mid-transaction or mid-loop discards the partial transaction or loop; no done or trip is recorded.

Verification
REQ-035 ap_start=1 for 1 cycle, ap_done=1 4 cycles later, ap_continue=1 -> start_cnt=1, done_cnt=1, last_lat=5, mod_busy low after done.
REQ-036 ap_start=ap_done=1 in the same cycle, repeated 3 times -> start_cnt=3, done_cnt=3, last_lat=1.
REQ-037 Codes pre=1, start=2, end=3, quit=2, post=1; state sequence 1,2,3,2,3,2,1 -> exec_cnt=1, last_trip=2, last_iter_cyc=2.
REQ-038 Same codes, sequence 1,2,1 -> exec_cnt=1, last_trip=0, loop_active=0.
REQ-039 finish=1 mid-loop, then further state activity -> frozen=1, all outputs unchanged.
REQ-040 reset=0 mid-transaction -> all outputs 0 immediately, without waiting for a clock edge.
